// File: rtl/pe_sequencer_pkg.sv
// Shared PE control encodings and sequencer state codes.
package pe_sequencer_pkg;

   localparam int PE_CTRL_W = 3;

   // bit0 selects input_psum, bit1 clears the accumulator
   localparam logic [PE_CTRL_W-1:0] CTRL_MAC  = 3'b000;
   localparam logic [PE_CTRL_W-1:0] CTRL_CLR  = 3'b010;
   localparam logic [PE_CTRL_W-1:0] CTRL_PSUM = 3'b001;

   localparam int ST_W = 3;
   localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
   localparam logic [ST_W-1:0] ST_LOAD = 3'd1;
   localparam logic [ST_W-1:0] ST_PSUM = 3'd2;
   localparam logic [ST_W-1:0] ST_OUT  = 3'd3;
   localparam logic [ST_W-1:0] ST_FIN  = 3'd4;

endpackage

// File: rtl/pe_sequencer.sv
// Drives one MAC PE through filter_size taps per output, optional vertical psum fold, and
// a valid/ready result handshake; PE controls are decoded combinationally from the FSM.
module pe_sequencer
   import pe_sequencer_pkg::*;
#(
   parameter int FS_W = 4,
   parameter int OC_W = 8
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 start,
   input  logic [FS_W-1:0]      filter_size,
   input  logic [OC_W-1:0]      num_outputs,
   input  logic                 use_psum_in,
   output logic                 busy,
   output logic                 done,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic                 pe_enable,
   output logic [PE_CTRL_W-1:0] pe_control,
   input  logic                 psum_in_valid,
   output logic                 psum_in_ready,
   output logic                 psum_out_valid,
   input  logic                 psum_out_ready
);

   localparam logic [FS_W-1:0] FS_ONE = 1;
   localparam logic [OC_W-1:0] OC_ONE = 1;

   logic [ST_W-1:0] state_q, state_d;
   logic [FS_W-1:0] tap_cnt_q, tap_cnt_d;
   logic [FS_W-1:0] fs_q, fs_d;
   logic [OC_W-1:0] out_cnt_q, out_cnt_d;
   logic [OC_W-1:0] no_q, no_d;
   logic            use_psum_q, use_psum_d;
   logic            last_tap, last_out;

   // Limits come from the latched config so mid-run input changes have no effect
   assign last_tap = (tap_cnt_q == fs_q - FS_ONE);
   assign last_out = (out_cnt_q == no_q - OC_ONE);

   always_comb begin
      state_d        = state_q;
      tap_cnt_d      = tap_cnt_q;
      out_cnt_d      = out_cnt_q;
      fs_d           = fs_q;
      no_d           = no_q;
      use_psum_d     = use_psum_q;
      pe_enable      = 1'b0;
      pe_control     = CTRL_MAC;
      data_ready     = 1'b0;
      psum_out_valid = 1'b0;
      psum_in_ready  = 1'b0;
      done           = 1'b0;
      busy           = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if ((filter_size != '0) && (num_outputs != '0)) begin
                  fs_d       = filter_size;
                  no_d       = num_outputs;
                  use_psum_d = use_psum_in;
                  tap_cnt_d  = '0;
                  out_cnt_d  = '0;
                  state_d    = ST_LOAD;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_LOAD: begin
            data_ready = 1'b1;
            if (data_valid) begin
               pe_enable  = 1'b1;
               pe_control = (tap_cnt_q == '0) ? CTRL_CLR : CTRL_MAC;
               if (last_tap) begin
                  tap_cnt_d = '0;
                  state_d   = use_psum_q ? ST_PSUM : ST_OUT;
               end else begin
                  tap_cnt_d = tap_cnt_q + FS_ONE;
               end
            end
         end
         ST_PSUM: begin
            if (psum_in_valid) begin
               pe_enable  = 1'b1;
               pe_control = CTRL_PSUM;
               state_d    = ST_OUT;
            end
         end
         ST_OUT: begin
            psum_out_valid = 1'b1;
            // Vertical psum is released only together with the finished result
            psum_in_ready  = use_psum_q & psum_out_ready;
            if (psum_out_ready) begin
               if (last_out) begin
                  state_d = ST_FIN;
               end else begin
                  out_cnt_d = out_cnt_q + OC_ONE;
                  state_d   = ST_LOAD;
               end
            end
         end
         ST_FIN: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q    <= ST_IDLE;
         tap_cnt_q  <= '0;
         out_cnt_q  <= '0;
         fs_q       <= '0;
         no_q       <= '0;
         use_psum_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tap_cnt_q  <= tap_cnt_d;
         out_cnt_q  <= out_cnt_d;
         fs_q       <= fs_d;
         no_q       <= no_d;
         use_psum_q <= use_psum_d;
      end
   end

endmodule

// File: tb/tb_pe_sequencer.sv
// Randomized bench for pe_sequencer with a behavioural PE and an arithmetic reference for each output.
module tb_pe_sequencer;

   localparam int FS_W = 4;
   localparam int OC_W = 8;

   logic            clk = 1'b0;
   logic            rstb = 1'b0;
   logic            start = 1'b0;
   logic [FS_W-1:0] filter_size = '0;
   logic [OC_W-1:0] num_outputs = '0;
   logic            use_psum_in = 1'b0;
   logic            busy, done, data_ready, pe_enable, psum_in_ready, psum_out_valid;
   logic [2:0]      pe_control;
   logic            data_valid = 1'b0;
   logic            psum_in_valid = 1'b0;
   logic            psum_out_ready = 1'b0;

   logic [7:0]      ifmap = '0;
   logic [7:0]      filter = '0;
   logic [15:0]     input_psum = '0;
   int              acc = 0;

   int tf [0:255];
   int tx [0:255];
   int tp [0:31];

   int checks = 0;
   int errors = 0;
   int got[$];
   int done_cnt, en_cnt, pir_cnt, first_valid_cyc, done_cyc;

   always #5 clk = ~clk;

   pe_sequencer #(.FS_W(FS_W), .OC_W(OC_W)) dut (
      .clk(clk), .rstb(rstb), .start(start), .filter_size(filter_size),
      .num_outputs(num_outputs), .use_psum_in(use_psum_in), .busy(busy), .done(done),
      .data_valid(data_valid), .data_ready(data_ready), .pe_enable(pe_enable),
      .pe_control(pe_control), .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready),
      .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready)
   );

   // Behavioural PE: the accumulator the sequencer is steering
   always @(posedge clk) begin
      if (pe_enable) begin
         case (pe_control)
            3'b010:  acc <= int'(ifmap) * int'(filter);
            3'b000:  acc <= acc + int'(ifmap) * int'(filter);
            3'b001:  acc <= acc + int'(input_psum);
            default: acc <= 32'h0BAD_0BAD;
         endcase
      end
   end

   function automatic int exp_out(input int k, input int s, input bit up);
      int sum = 0;
      for (int t = 0; t < s; t++) sum += tf[k*s+t] * tx[k*s+t];
      if (up) sum += tp[k];
      return sum;
   endfunction

   // pat=1: data_valid alternates 1,0,1,... and psum_out_ready waits 5 OUT cycles
   task automatic run_job(input int s, input int n, input bit up, input int vpct,
                          input int rpct, input bit poke, input bit pat);
      int  tap_idx = 0, out_idx = 0, tap_in_out = 0, out_seen = 0, c = 0, prev_acc = 0;
      bit  hold = 0, fin = 0;
      got.delete();
      done_cnt = 0; en_cnt = 0; pir_cnt = 0; first_valid_cyc = -1; done_cyc = -1;
      @(posedge clk); #1;
      start = 1'b1; filter_size = FS_W'(s); num_outputs = OC_W'(n); use_psum_in = up;
      data_valid = 1'b0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      while (c < 3000 && !fin) begin
         filter_size = FS_W'($urandom); num_outputs = OC_W'($urandom); use_psum_in = 1'($urandom);
         start = poke ? ($urandom_range(3) == 0) : 1'b0;
         if (pat) begin
            data_valid = (c % 2 == 0); psum_in_valid = 1'b1; psum_out_ready = (out_seen >= 5);
         end else begin
            data_valid     = ($urandom_range(99) < vpct);
            psum_in_valid  = ($urandom_range(99) < vpct);
            psum_out_ready = ($urandom_range(99) < rpct);
         end
         filter = 8'(tf[tap_idx]); ifmap = 8'(tx[tap_idx]); input_psum = 16'(tp[out_idx]);
         @(negedge clk);
         if (hold) begin
            checks++;
            if (psum_out_valid !== 1'b1 || acc !== prev_acc) begin
               errors++;
               $display("FAIL hold_stable cyc=%0d valid=%b acc=%0d expected valid=1 acc=%0d", c, psum_out_valid, acc, prev_acc);
            end
         end
         if (data_ready && data_valid) begin
            checks++;
            if (pe_enable !== 1'b1 || pe_control !== ((tap_in_out == 0) ? 3'b010 : 3'b000)) begin
               errors++;
               $display("FAIL tap_ctrl cyc=%0d tap=%0d en=%b ctrl=%b", c, tap_in_out, pe_enable, pe_control);
            end
         end
         if (!pe_enable) begin
            checks++;
            if (pe_control !== 3'b000) begin
               errors++;
               $display("FAIL idle_ctrl cyc=%0d ctrl=%b expected 000", c, pe_control);
            end
         end
         checks++;
         if (data_ready && psum_out_valid) begin
            errors++;
            $display("FAIL overlap cyc=%0d data_ready and psum_out_valid both high", c);
         end
         checks++;
         if (psum_in_ready !== (psum_out_valid && psum_out_ready && up)) begin
            errors++;
            $display("FAIL psum_in_ready cyc=%0d got %b expected %b", c, psum_in_ready, psum_out_valid && psum_out_ready && up);
         end
         if (psum_out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = c;
            out_seen++;
            checks++;
            if (out_idx >= n || acc !== exp_out(out_idx, s, up)) begin
               errors++;
               $display("FAIL result cyc=%0d idx=%0d got %0d expected %0d", c, out_idx, acc, exp_out(out_idx, s, up));
            end
         end
         if (pe_enable) en_cnt++;
         if (psum_in_ready) pir_cnt++;
         if (done) begin done_cnt++; done_cyc = c; fin = 1; end
         if (data_ready && data_valid) begin
            tap_idx++;
            tap_in_out = (tap_in_out == s - 1) ? 0 : tap_in_out + 1;
         end
         if (psum_out_valid && psum_out_ready) begin
            got.push_back(acc);
            out_idx++;
            out_seen = 0;
         end
         hold = psum_out_valid && !psum_out_ready;
         prev_acc = acc;
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0; data_valid = 1'b0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL job_timeout s=%0d n=%0d no done within 3000 cycles", s, n);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL post_done busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic load_basic_taps();
      tf[0] = 4; tf[1] = 5; tf[2] = 6;
      tx[0] = 1; tx[1] = 2; tx[2] = 3;
      tp[0] = 100;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({busy, done, data_ready, pe_enable, pe_control, psum_out_valid, psum_in_ready} !== 9'b0) begin
         errors++;
         $display("FAIL reset_state outputs=%b expected all 0", {busy, done, data_ready, pe_enable, pe_control, psum_out_valid, psum_in_ready});
      end
      @(posedge clk); #1;
      rstb = 1'b1;
   endtask

   task automatic test_basic();
      load_basic_taps();
      run_job(3, 1, 1'b0, 100, 100, 1'b0, 1'b0);
      checks++;
      if (got.size() != 1 || got[0] !== 32) begin
         errors++;
         $display("FAIL basic_result count=%0d first=%0d expected 1 output of 32", got.size(), (got.size() > 0) ? got[0] : -1);
      end
      checks++;
      if (first_valid_cyc != 3 || done_cyc != 4 || en_cnt != 3 || done_cnt != 1) begin
         errors++;
         $display("FAIL basic_timing valid@%0d done@%0d en=%0d dones=%0d expected 3 4 3 1", first_valid_cyc, done_cyc, en_cnt, done_cnt);
      end
   endtask

   task automatic test_psum();
      load_basic_taps();
      run_job(3, 1, 1'b1, 100, 100, 1'b0, 1'b0);
      checks++;
      if (got.size() != 1 || got[0] !== 132) begin
         errors++;
         $display("FAIL psum_result count=%0d first=%0d expected 1 output of 132", got.size(), (got.size() > 0) ? got[0] : -1);
      end
      checks++;
      if (first_valid_cyc != 4 || en_cnt != 4 || pir_cnt != 1) begin
         errors++;
         $display("FAIL psum_timing valid@%0d en=%0d psum_in_ready=%0d expected 4 4 1", first_valid_cyc, en_cnt, pir_cnt);
      end
   endtask

   task automatic test_backpressure();
      load_basic_taps();
      run_job(3, 1, 1'b0, 100, 100, 1'b0, 1'b1);
      checks++;
      if (got.size() != 1 || got[0] !== 32 || en_cnt != 3) begin
         errors++;
         $display("FAIL backpressure_result count=%0d en=%0d expected 1 output of 32 and 3 enables", got.size(), en_cnt);
      end
      checks++;
      if (first_valid_cyc != 5 || done_cyc != 11) begin
         errors++;
         $display("FAIL backpressure_timing valid@%0d done@%0d expected 5 11", first_valid_cyc, done_cyc);
      end
   endtask

   task automatic test_back_to_back();
      tf[0] = 1; tx[0] = 2; tf[1] = 3; tx[1] = 4;
      tf[2] = 2; tx[2] = 2; tf[3] = 2; tx[3] = 2;
      tf[4] = 0; tx[4] = 9; tf[5] = 5; tx[5] = 1;
      run_job(2, 3, 1'b0, 100, 100, 1'b0, 1'b0);
      checks++;
      if (got.size() != 3 || got[0] !== 14 || got[1] !== 8 || got[2] !== 5) begin
         errors++;
         $display("FAIL b2b_results count=%0d expected 14 8 5 in order", got.size());
      end
      checks++;
      if (done_cnt != 1 || en_cnt != 6) begin
         errors++;
         $display("FAIL b2b_counts dones=%0d en=%0d expected 1 6", done_cnt, en_cnt);
      end
   endtask

   task automatic test_reset_mid();
      load_basic_taps();
      @(posedge clk); #1;
      start = 1'b1; filter_size = 4'd3; num_outputs = 8'd1; use_psum_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; data_valid = 1'b1; filter = 8'(tf[0]); ifmap = 8'(tx[0]);
      @(posedge clk); #2;
      rstb = 1'b0;
      #1;
      checks++;
      if ({busy, done, data_ready, pe_enable, pe_control, psum_out_valid, psum_in_ready} !== 9'b0) begin
         errors++;
         $display("FAIL reset_mid outputs=%b expected all 0", {busy, done, data_ready, pe_enable, pe_control, psum_out_valid, psum_in_ready});
      end
      data_valid = 1'b0;
      @(posedge clk); #1;
      rstb = 1'b1;
      run_job(3, 1, 1'b0, 100, 100, 1'b0, 1'b0);
      checks++;
      if (got.size() != 1 || got[0] !== 32) begin
         errors++;
         $display("FAIL reset_recover count=%0d expected 1 output of 32", got.size());
      end
   endtask

   task automatic test_degenerate();
      int fs_v [2] = '{0, 3};
      int no_v [2] = '{2, 0};
      for (int k = 0; k < 2; k++) begin
         int dn = 0, en = 0, dc = -1;
         @(posedge clk); #1;
         start = 1'b1; filter_size = FS_W'(fs_v[k]); num_outputs = OC_W'(no_v[k]); data_valid = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) begin dn++; dc = c; end
            if (pe_enable || data_ready) en++;
            @(posedge clk); #1;
         end
         data_valid = 1'b0;
         checks++;
         if (dn != 1 || dc != 0 || en != 0) begin
            errors++;
            $display("FAIL degenerate fs=%0d n=%0d dones=%0d done@%0d pe_activity=%0d expected 1 0 0", fs_v[k], no_v[k], dn, dc, en);
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 25; it++) begin
         int  s = $urandom_range(1, 6);
         int  n = $urandom_range(1, 5);
         bit  up = 1'($urandom);
         int  bad = 0;
         for (int i = 0; i < s * n; i++) begin
            tf[i] = $urandom_range(255); tx[i] = $urandom_range(255);
         end
         for (int i = 0; i < n; i++) tp[i] = $urandom_range(65535);
         run_job(s, n, up, $urandom_range(40, 100), $urandom_range(30, 100), 1'b1, 1'b0);
         for (int i = 0; i < n; i++)
            if (i >= got.size() || got[i] !== exp_out(i, s, up)) bad++;
         checks++;
         if (bad != 0 || got.size() != n || done_cnt != 1 || en_cnt != n * s + (up ? n : 0)) begin
            errors++;
            $display("FAIL random it=%0d s=%0d n=%0d up=%0d outputs=%0d bad=%0d en=%0d dones=%0d", it, s, n, up, got.size(), bad, en_cnt, done_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_psum();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_degenerate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
